// File: rtl/trap_arbiter.sv
// Trap controller: registers pipeline/interrupt state, arbitrates one exception or interrupt
// and presents it to the CSR unit through a REQ/ACK handshake followed by a short hold-off.
module trap_arbiter #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned NUM_STAGES  = 4,
    parameter int unsigned NUM_INT     = 8,
    parameter int unsigned CODE_W      = 4,
    parameter int unsigned HOLD_CYCLES = 2
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       FLUSH,
    input  logic                       MEM_WAIT,
    input  logic [NUM_STAGES*XLEN-1:0] STAGE_PC,
    input  logic [NUM_STAGES-1:0]      STAGE_VALID,
    input  logic                       EXC_EN,
    input  logic [CODE_W-1:0]          EXC_CODE,
    input  logic                       INT_ALLOW,
    input  logic [NUM_INT-1:0]         INT_PEND,
    input  logic [NUM_INT-1:0]         INT_MASK,
    input  logic [1:0]                 TRAP_VEC_MODE,
    input  logic [XLEN-1:0]            TRAP_VEC_BASE,
    output logic                       TRAP_REQ,
    input  logic                       TRAP_ACK,
    output logic [XLEN-1:0]            TRAP_PC,
    output logic [XLEN-1:0]            TRAP_CODE,
    output logic [XLEN-1:0]            TRAP_JMP_TO,
    output logic [NUM_INT-1:0]         INT_CLAIM,
    output logic                       BUSY
);

    localparam int unsigned IDX_W = $clog2(NUM_INT);
    localparam int unsigned CNT_W = $clog2(HOLD_CYCLES + 1);

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StHold
    } state_e;

    // Registered inputs
    logic [NUM_STAGES*XLEN-1:0] stage_pc_q;
    logic [NUM_STAGES-1:0]      stage_valid_q;
    logic                       exc_en_q;
    logic [CODE_W-1:0]          exc_code_q;
    logic                       int_allow_q;
    logic [NUM_INT-1:0]         int_pend_q;
    logic [NUM_INT-1:0]         int_mask_q;
    logic [1:0]                 vec_mode_q;
    logic [XLEN-1:0]            vec_base_q;

    always_ff @(posedge CLK) begin
        if (RST || (FLUSH && !MEM_WAIT)) begin
            stage_pc_q    <= '0;
            stage_valid_q <= '0;
            exc_en_q      <= 1'b0;
            exc_code_q    <= '0;
            int_allow_q   <= 1'b0;
            int_pend_q    <= '0;
            int_mask_q    <= '0;
            vec_mode_q    <= 2'd0;
            vec_base_q    <= '0;
        end else if (!MEM_WAIT) begin
            stage_pc_q    <= STAGE_PC;
            stage_valid_q <= STAGE_VALID;
            exc_en_q      <= EXC_EN;
            exc_code_q    <= EXC_CODE;
            int_allow_q   <= INT_ALLOW;
            int_pend_q    <= INT_PEND;
            int_mask_q    <= INT_MASK;
            vec_mode_q    <= TRAP_VEC_MODE;
            vec_base_q    <= TRAP_VEC_BASE;
        end
    end

    // Candidate selection
    logic [NUM_INT-1:0] int_active;
    logic               int_hit;
    logic [IDX_W-1:0]   int_idx;
    logic               int_take;
    logic               cand_valid;
    logic               cand_is_int;
    logic [XLEN-1:0]    cand_pc;
    logic [XLEN-1:0]    cand_code;
    logic [XLEN-1:0]    cand_target;
    logic [XLEN-1:0]    base_aligned;
    logic [XLEN-1:0]    vec_offset;

    always_comb begin
        int_active = int_pend_q & int_mask_q;
        int_hit    = 1'b0;
        int_idx    = '0;
        // Descending scan so the lowest active channel is the one left standing
        for (int i = NUM_INT - 1; i >= 0; i--) begin
            if (int_active[i]) begin
                int_hit = 1'b1;
                int_idx = IDX_W'(i);
            end
        end
        int_take    = int_allow_q && int_hit;
        cand_valid  = exc_en_q || int_take;
        cand_is_int = !exc_en_q && int_take;
    end

    always_comb begin
        cand_pc = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            if (stage_valid_q[i]) begin
                cand_pc = stage_pc_q[i*XLEN +: XLEN];
            end
        end
    end

    always_comb begin
        base_aligned = vec_base_q & ~XLEN'(3);
        vec_offset   = {{(XLEN - IDX_W - 2){1'b0}}, int_idx, 2'b00};
        if (cand_is_int) begin
            cand_code = {1'b1, {(XLEN - 1 - IDX_W){1'b0}}, int_idx};
        end else begin
            cand_code = {{(XLEN - CODE_W){1'b0}}, exc_code_q};
        end
        // Exceptions are always direct; modes 2/3 fall back to direct as well
        if (cand_is_int && (vec_mode_q == 2'd1)) begin
            cand_target = base_aligned + vec_offset;
        end else begin
            cand_target = base_aligned;
        end
    end

    // Handshake FSM and latched trap record
    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0]    trap_pc_q, trap_pc_d;
    logic [XLEN-1:0]    trap_code_q, trap_code_d;
    logic [XLEN-1:0]    trap_jmp_q, trap_jmp_d;
    logic               trap_is_int_q, trap_is_int_d;
    logic [IDX_W-1:0]   trap_ch_q, trap_ch_d;
    logic [NUM_INT-1:0] claim_q, claim_d;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            trap_pc_q     <= '0;
            trap_code_q   <= '0;
            trap_jmp_q    <= '0;
            trap_is_int_q <= 1'b0;
            trap_ch_q     <= '0;
            claim_q       <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            trap_pc_q     <= trap_pc_d;
            trap_code_q   <= trap_code_d;
            trap_jmp_q    <= trap_jmp_d;
            trap_is_int_q <= trap_is_int_d;
            trap_ch_q     <= trap_ch_d;
            claim_q       <= claim_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        trap_pc_d     = trap_pc_q;
        trap_code_d   = trap_code_q;
        trap_jmp_d    = trap_jmp_q;
        trap_is_int_d = trap_is_int_q;
        trap_ch_d     = trap_ch_q;
        claim_d       = '0;

        unique case (state_q)
            StIdle: begin
                if (cand_valid && !MEM_WAIT) begin
                    trap_pc_d     = cand_pc;
                    trap_code_d   = cand_code;
                    trap_jmp_d    = cand_target;
                    trap_is_int_d = cand_is_int;
                    trap_ch_d     = int_idx;
                    state_d       = StReq;
                end
            end
            StReq: begin
                if (TRAP_ACK) begin
                    if (trap_is_int_q) begin
                        claim_d = NUM_INT'(1) << trap_ch_q;
                    end
                    cnt_d   = CNT_W'(HOLD_CYCLES - 1);
                    state_d = StHold;
                end
            end
            StHold: begin
                if (cnt_q == '0) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign TRAP_REQ    = (state_q == StReq);
    assign BUSY        = (state_q != StIdle);
    assign TRAP_PC     = trap_pc_q;
    assign TRAP_CODE   = trap_code_q;
    assign TRAP_JMP_TO = trap_jmp_q;
    assign INT_CLAIM   = claim_q;

endmodule

// File: tb/tb_trap_arbiter.sv
// Bench for trap_arbiter: cycle-by-cycle comparison against a behavioural model plus
// directed scenarios with hand-computed expectations.
module tb_trap_arbiter;

    localparam int XLEN = 32;
    localparam int NS   = 4;
    localparam int NI   = 8;
    localparam int CW   = 4;
    localparam int HOLD = 2;

    logic              CLK = 1'b0;
    logic              RST = 1'b1;
    logic              FLUSH, MEM_WAIT, EXC_EN, INT_ALLOW, TRAP_ACK;
    logic [NS*XLEN-1:0] STAGE_PC;
    logic [NS-1:0]     STAGE_VALID;
    logic [CW-1:0]     EXC_CODE;
    logic [NI-1:0]     INT_PEND, INT_MASK;
    logic [1:0]        TRAP_VEC_MODE;
    logic [XLEN-1:0]   TRAP_VEC_BASE;
    logic              TRAP_REQ, BUSY;
    logic [XLEN-1:0]   TRAP_PC, TRAP_CODE, TRAP_JMP_TO;
    logic [NI-1:0]     INT_CLAIM;

    trap_arbiter #(
        .XLEN(XLEN), .NUM_STAGES(NS), .NUM_INT(NI), .CODE_W(CW), .HOLD_CYCLES(HOLD)
    ) dut (
        .CLK(CLK), .RST(RST), .FLUSH(FLUSH), .MEM_WAIT(MEM_WAIT),
        .STAGE_PC(STAGE_PC), .STAGE_VALID(STAGE_VALID),
        .EXC_EN(EXC_EN), .EXC_CODE(EXC_CODE),
        .INT_ALLOW(INT_ALLOW), .INT_PEND(INT_PEND), .INT_MASK(INT_MASK),
        .TRAP_VEC_MODE(TRAP_VEC_MODE), .TRAP_VEC_BASE(TRAP_VEC_BASE),
        .TRAP_REQ(TRAP_REQ), .TRAP_ACK(TRAP_ACK),
        .TRAP_PC(TRAP_PC), .TRAP_CODE(TRAP_CODE), .TRAP_JMP_TO(TRAP_JMP_TO),
        .INT_CLAIM(INT_CLAIM), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    int pass_cnt = 0;
    int total    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    endtask

    // Behavioural model: sampled copy of the inputs plus the trap record
    logic [31:0] r_pc [NS];
    logic [3:0]  r_valid;
    logic        r_exc, r_allow;
    logic [3:0]  r_code;
    logic [7:0]  r_pend, r_mask;
    logic [1:0]  r_mode;
    logic [31:0] r_base;
    int          m_state;  // 0 idle, 1 request pending, 2 hold-off
    int          m_cnt, m_ch, s;
    logic        m_isint, take_int;
    logic [31:0] m_pc, m_code, m_jmp;
    logic [7:0]  m_claim, nclaim, act;

    function automatic int top_valid(input logic [3:0] v);
        return $clog2(int'(v) + 1) - 1;
    endfunction

    function automatic int low_chan(input logic [7:0] p);
        logic [7:0] lb;
        lb = p & (~p + 8'd1);
        return $clog2(int'(lb));
    endfunction

    always @(posedge CLK) begin
        if (RST) begin
            m_state = 0; m_cnt = 0; m_isint = 0; m_ch = 0;
            m_pc = 0; m_code = 0; m_jmp = 0; m_claim = 0;
            for (int i = 0; i < NS; i++) r_pc[i] = 0;
            r_valid = 0; r_exc = 0; r_code = 0; r_allow = 0;
            r_pend = 0; r_mask = 0; r_mode = 0; r_base = 0;
        end else begin
            nclaim = 0;
            case (m_state)
                0: begin
                    act      = r_pend & r_mask;
                    take_int = !r_exc && r_allow && (act != 0);
                    if ((r_exc || take_int) && !MEM_WAIT) begin
                        s    = top_valid(r_valid);
                        m_pc = (s < 0) ? 32'd0 : r_pc[s];
                        if (take_int) begin
                            m_ch    = low_chan(act);
                            m_isint = 1;
                            m_code  = 32'h8000_0000 + 32'(m_ch);
                            m_jmp   = {r_base[31:2], 2'b00}
                                      + ((r_mode == 2'd1) ? 32'(m_ch * 4) : 32'd0);
                        end else begin
                            m_isint = 0;
                            m_code  = {28'd0, r_code};
                            m_jmp   = {r_base[31:2], 2'b00};
                        end
                        m_state = 1;
                    end
                end
                1: if (TRAP_ACK) begin
                    if (m_isint) nclaim = 8'(1 << m_ch);
                    m_cnt   = HOLD - 1;
                    m_state = 2;
                end
                default: if (m_cnt == 0) m_state = 0; else m_cnt--;
            endcase
            m_claim = nclaim;
            if (!MEM_WAIT) begin
                for (int i = 0; i < NS; i++) r_pc[i] = FLUSH ? 32'd0 : STAGE_PC[i*32 +: 32];
                r_valid = FLUSH ? 4'd0 : STAGE_VALID;
                r_exc   = FLUSH ? 1'b0 : EXC_EN;
                r_code  = FLUSH ? 4'd0 : EXC_CODE;
                r_allow = FLUSH ? 1'b0 : INT_ALLOW;
                r_pend  = FLUSH ? 8'd0 : INT_PEND;
                r_mask  = FLUSH ? 8'd0 : INT_MASK;
                r_mode  = FLUSH ? 2'd0 : TRAP_VEC_MODE;
                r_base  = FLUSH ? 32'd0 : TRAP_VEC_BASE;
            end
        end
        #1;
        chk("model_req",   {31'd0, TRAP_REQ}, {31'd0, m_state == 1});
        chk("model_busy",  {31'd0, BUSY}, {31'd0, m_state != 0});
        chk("model_claim", {24'd0, INT_CLAIM}, {24'd0, m_claim});
        chk("model_pc",    TRAP_PC, m_pc);
        chk("model_code",  TRAP_CODE, m_code);
        chk("model_jmp",   TRAP_JMP_TO, m_jmp);
    end

    task automatic clr_in();
        FLUSH = 0; MEM_WAIT = 0; EXC_EN = 0; EXC_CODE = 0; INT_ALLOW = 0; TRAP_ACK = 0;
        INT_PEND = 0; INT_MASK = 0; STAGE_PC = '0; STAGE_VALID = 0;
        TRAP_VEC_MODE = 0; TRAP_VEC_BASE = 0;
    endtask

    task automatic nclk(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic wait_req(input string name);
        for (int k = 0; k < 10 && !TRAP_REQ; k++) @(negedge CLK);
        chk(name, {31'd0, TRAP_REQ}, 32'd1);
    endtask

    task automatic ack();
        TRAP_ACK = 1;
        nclk(1);
        TRAP_ACK = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        clr_in();
        nclk(2);
        chk("reset_req", {31'd0, TRAP_REQ}, 32'd0);
        chk("reset_busy", {31'd0, BUSY}, 32'd0);
        chk("reset_pc", TRAP_PC, 32'd0);
        chk("reset_claim", {24'd0, INT_CLAIM}, 32'd0);
        RST = 0;

        // Exception only, vectored mode still direct
        STAGE_PC = {32'h100, 32'h0C0, 32'h080, 32'h040};
        STAGE_VALID = 4'b1111; EXC_EN = 1; EXC_CODE = 4'd2;
        TRAP_VEC_MODE = 2'd1; TRAP_VEC_BASE = 32'h8000_0003;
        nclk(1);
        EXC_EN = 0;
        nclk(1);
        chk("exc_req_latency", {31'd0, TRAP_REQ}, 32'd1);
        chk("exc_pc", TRAP_PC, 32'h100);
        chk("exc_code", TRAP_CODE, 32'h2);
        chk("exc_jmp", TRAP_JMP_TO, 32'h8000_0000);
        ack();
        chk("exc_no_claim", {24'd0, INT_CLAIM}, 32'd0);
        chk("exc_req_drop", {31'd0, TRAP_REQ}, 32'd0);
        nclk(1);
        chk("exc_hold_busy", {31'd0, BUSY}, 32'd1);
        nclk(1);
        chk("exc_busy_clear", {31'd0, BUSY}, 32'd0);

        // Interrupt priority, lowest channel wins
        clr_in();
        INT_PEND = 8'b1010_0100; INT_MASK = 8'hFF; INT_ALLOW = 1;
        TRAP_VEC_MODE = 2'd1; TRAP_VEC_BASE = 32'h1000;
        nclk(1);
        INT_PEND = 0;
        wait_req("int_req");
        chk("int_code", TRAP_CODE, 32'h8000_0002);
        chk("int_jmp", TRAP_JMP_TO, 32'h1008);
        chk("int_pc_none_valid", TRAP_PC, 32'd0);
        ack();
        chk("int_claim", {24'd0, INT_CLAIM}, 32'h04);
        nclk(1);
        chk("int_claim_pulse", {24'd0, INT_CLAIM}, 32'd0);
        nclk(1);
        chk("int_busy_clear", {31'd0, BUSY}, 32'd0);

        // Exception beats interrupt; masking blocks interrupts
        clr_in();
        EXC_EN = 1; EXC_CODE = 4'd5; INT_PEND = 8'h01; INT_MASK = 8'hFF; INT_ALLOW = 1;
        nclk(1);
        EXC_EN = 0; INT_PEND = 0;
        wait_req("exc_vs_int_req");
        chk("exc_vs_int_code", TRAP_CODE, 32'h5);
        ack(); nclk(2);
        INT_ALLOW = 0; INT_PEND = 8'hFF;
        nclk(4);
        chk("allow_off_no_req", {31'd0, TRAP_REQ}, 32'd0);
        INT_ALLOW = 1; INT_MASK = 8'h00;
        nclk(4);
        chk("mask_off_no_req", {31'd0, TRAP_REQ}, 32'd0);

        // PC select and vector wrap
        clr_in();
        STAGE_PC = {32'h300, 32'h200, 32'h44, 32'h11};
        STAGE_VALID = 4'b0011; EXC_EN = 1; EXC_CODE = 4'd3;
        nclk(1);
        EXC_EN = 0;
        wait_req("pcsel_req");
        chk("pcsel_pc", TRAP_PC, 32'h44);
        ack(); nclk(2);
        clr_in();
        TRAP_VEC_BASE = 32'hFFFF_FFFC; TRAP_VEC_MODE = 2'd1;
        INT_PEND = 8'b0000_0100; INT_MASK = 8'hFF; INT_ALLOW = 1;
        nclk(1);
        INT_PEND = 0;
        wait_req("wrap_req");
        chk("wrap_jmp", TRAP_JMP_TO, 32'h4);
        ack(); nclk(2);
        TRAP_VEC_BASE = 32'h2000; TRAP_VEC_MODE = 2'd2; INT_PEND = 8'b1000_0000;
        nclk(1);
        INT_PEND = 0;
        wait_req("mode2_req");
        chk("mode2_code", TRAP_CODE, 32'h8000_0007);
        chk("mode2_jmp", TRAP_JMP_TO, 32'h2000);
        ack(); nclk(2);

        // Stall freezes sampling and blocks the trap
        clr_in();
        STAGE_PC = {32'h500, 96'd0}; STAGE_VALID = 4'b1000; EXC_EN = 1; EXC_CODE = 4'd7;
        nclk(1);
        MEM_WAIT = 1; EXC_EN = 0;
        for (int k = 0; k < 3; k++) begin
            nclk(1);
            chk("stall_no_req", {31'd0, TRAP_REQ}, 32'd0);
        end
        MEM_WAIT = 0;
        nclk(1);
        chk("stall_release_req", {31'd0, TRAP_REQ}, 32'd1);
        chk("stall_code", TRAP_CODE, 32'h7);

        // Outputs stay frozen in REQ whatever the inputs do
        FLUSH = 1; EXC_EN = 1; EXC_CODE = 4'hF; INT_PEND = 8'hFF; INT_MASK = 8'hFF;
        INT_ALLOW = 1; STAGE_PC = '1; STAGE_VALID = 4'hF; TRAP_VEC_BASE = 32'h1234_5678;
        nclk(1);
        FLUSH = 0; MEM_WAIT = 1;
        nclk(1);
        MEM_WAIT = 0;
        nclk(1);
        chk("frozen_pc", TRAP_PC, 32'h500);
        chk("frozen_code", TRAP_CODE, 32'h7);
        chk("frozen_req", {31'd0, TRAP_REQ}, 32'd1);
        clr_in();
        nclk(1);
        ack(); nclk(2);

        // Flush in idle alongside a candidate: candidate still taken
        INT_PEND = 8'b0001_0000; INT_MASK = 8'hFF; INT_ALLOW = 1;
        nclk(1);
        FLUSH = 1; INT_PEND = 0;
        nclk(1);
        chk("flush_same_cycle_req", {31'd0, TRAP_REQ}, 32'd1);
        chk("flush_same_cycle_code", TRAP_CODE, 32'h8000_0004);
        FLUSH = 0;
        ack(); nclk(2);

        // Persistent exception re-traps on idle re-entry
        clr_in();
        EXC_EN = 1; EXC_CODE = 4'd1;
        nclk(2);
        chk("persist_req", {31'd0, TRAP_REQ}, 32'd1);
        ack();
        nclk(2);
        chk("persist_hold_no_req", {31'd0, TRAP_REQ}, 32'd0);
        nclk(1);
        chk("persist_retrap", {31'd0, TRAP_REQ}, 32'd1);
        EXC_EN = 0;
        nclk(1);
        ack(); nclk(3);

        // Reset mid-REQ, with a concurrent ACK, aborts silently
        clr_in();
        INT_PEND = 8'b0000_0010; INT_MASK = 8'hFF; INT_ALLOW = 1;
        nclk(1);
        INT_PEND = 0;
        wait_req("rst_mid_req");
        RST = 1; TRAP_ACK = 1;
        nclk(1);
        chk("rst_req", {31'd0, TRAP_REQ}, 32'd0);
        chk("rst_busy", {31'd0, BUSY}, 32'd0);
        chk("rst_pc", TRAP_PC, 32'd0);
        chk("rst_code", TRAP_CODE, 32'd0);
        chk("rst_jmp", TRAP_JMP_TO, 32'd0);
        chk("rst_claim", {24'd0, INT_CLAIM}, 32'd0);
        RST = 0; TRAP_ACK = 0;
        nclk(1);
        chk("rst_no_late_claim", {24'd0, INT_CLAIM}, 32'd0);
        nclk(2);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
